// File: rtl/reorder_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reorder_buffer
//   In-order reorder buffer that sits directly after Dispatch. It allocates up
//   to DISP_WIDTH entries per cycle in program order, marks entries done from
//   the per-FU completion ports, and retires up to DISP_WIDTH done entries per
//   cycle from the head. rob_full is back-pressure to Dispatch.
//
//   Optional feature: define ROB_FLUSH_EN to add the flush port. A flush
//   empties the buffer at the edge and overrides alloc/complete/retire.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   alloc_valid     per-lane allocate request
//   alloc_dst_reg   per-lane destination register (packed, lane 0 in LSBs)
//   alloc_pc        per-lane PC (packed)
//   alloc_idx       per-lane ROB index handed out (combinational)
//   rob_full        fewer than DISP_WIDTH free entries
//   cmpl_valid      per-FU completion strobe
//   cmpl_idx        per-FU ROB index of the completing instruction
//   retire_valid    per-lane retire strobe (in order from head)
//   retire_dst_reg  destination register of each retiring entry
//   retire_pc       PC of each retiring entry
//   rob_count       occupied entries (registered)
//   flush           empty the buffer (ROB_FLUSH_EN builds only)
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_DEPTH  = 32,
    parameter int DISP_WIDTH = 2,
    parameter int NUM_FUS    = 4,
    parameter int REG_W      = 5,
    parameter int PC_W       = 32,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ROB_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic [DISP_WIDTH-1:0]       alloc_valid,
    input  logic [DISP_WIDTH*REG_W-1:0] alloc_dst_reg,
    input  logic [DISP_WIDTH*PC_W-1:0]  alloc_pc,
    output logic [DISP_WIDTH*IDX_W-1:0] alloc_idx,
    output logic                        rob_full,
    input  logic [NUM_FUS-1:0]          cmpl_valid,
    input  logic [NUM_FUS*IDX_W-1:0]    cmpl_idx,
    output logic [DISP_WIDTH-1:0]       retire_valid,
    output logic [DISP_WIDTH*REG_W-1:0] retire_dst_reg,
    output logic [DISP_WIDTH*PC_W-1:0]  retire_pc,
    output logic [IDX_W:0]              rob_count
);

    localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);
    // Full when ROB_DEPTH - count < DISP_WIDTH, i.e. count > ROB_DEPTH - DISP_WIDTH.
    localparam logic [IDX_W:0] FULL_LIMIT = (IDX_W+1)'(ROB_DEPTH - DISP_WIDTH);

    logic [IDX_W-1:0]      head, tail;
    logic [IDX_W:0]        count;
    logic [ROB_DEPTH-1:0]  valid, done;
    logic [REG_W-1:0]      dst_mem [ROB_DEPTH];
    logic [PC_W-1:0]       pc_mem  [ROB_DEPTH];

    logic [DISP_WIDTH-1:0] alloc_en;
    logic [IDX_W:0]        alloc_num, alloc_adv, ret_num;
    logic [IDX_W-1:0]      lane_idx [DISP_WIDTH];
    logic [IDX_W-1:0]      ret_idx  [DISP_WIDTH];
    logic                  ret_chain;

    assign rob_full  = count > FULL_LIMIT;
    assign rob_count = count;
    // Requests under full are dropped entirely; Dispatch is not allowed to make them.
    assign alloc_en  = rob_full ? '0 : alloc_valid;
    assign alloc_adv = rob_full ? '0 : alloc_num;

    // Lanes are packed: each requesting lane takes the next slot after the
    // lower requesting lanes, so a lone upper-lane request takes the tail.
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves a value held and no latch is inferred.
    always_comb begin
        alloc_num = '0;
        alloc_idx = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            lane_idx[i] = tail + alloc_num[IDX_W-1:0];
            alloc_idx[i*IDX_W +: IDX_W] = lane_idx[i];
            if (alloc_valid[i]) alloc_num = alloc_num + ONE;
        end
    end

    // Retire is strictly in order: lane i only retires if every lane below it does.
    always_comb begin
        ret_num        = '0;
        ret_chain      = 1'b1;
        retire_valid   = '0;
        retire_dst_reg = '0;
        retire_pc      = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            ret_idx[i] = head + IDX_W'(i);
            ret_chain  = ret_chain & valid[ret_idx[i]] & done[ret_idx[i]];
            retire_valid[i] = ret_chain;
            retire_dst_reg[i*REG_W +: REG_W] = dst_mem[ret_idx[i]];
            retire_pc[i*PC_W +: PC_W]        = pc_mem[ret_idx[i]];
            if (ret_chain) ret_num = ret_num + ONE;
        end
`ifdef ROB_FLUSH_EN
        if (flush) begin
            retire_valid = '0;
            ret_num      = '0;
        end
`endif
    end

    // Control state. Updates are ordered complete -> retire -> allocate so a
    // completion aimed at a slot allocated this same edge loses to the
    // allocation, which starts the entry with done=0.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst
`ifdef ROB_FLUSH_EN
            || flush
`endif
        ) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (cmpl_valid[f] && valid[cmpl_idx[f*IDX_W +: IDX_W]])
                    done[cmpl_idx[f*IDX_W +: IDX_W]] <= 1'b1;
            end
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (retire_valid[i]) begin
                    valid[ret_idx[i]] <= 1'b0;
                    done[ret_idx[i]]  <= 1'b0;
                end
            end
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (alloc_en[i]) begin
                    valid[lane_idx[i]] <= 1'b1;
                    done[lane_idx[i]]  <= 1'b0;
                end
            end
            head  <= head + ret_num[IDX_W-1:0];
            tail  <= tail + alloc_adv[IDX_W-1:0];
            count <= count + alloc_adv - ret_num;
        end
    end

    // NOTE: payload storage has no reset; an entry's payload is only ever
    // observed while its valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (alloc_en[i]) begin
                dst_mem[lane_idx[i]] <= alloc_dst_reg[i*REG_W +: REG_W];
                pc_mem[lane_idx[i]]  <= alloc_pc[i*PC_W +: PC_W];
            end
        end
    end

    // Dispatch must honour rob_full.
    alloc_when_full_a: assert property (
        @(posedge clk) disable iff (rst) !(rob_full && (|alloc_valid))
    );

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed bench for reorder_buffer (default parameters). A table of
//   per-cycle vectors covers out-of-order completion, same-cycle and
//   duplicate completions; hand-written sequences cover full, payload,
//   reset mid-operation, wrap, lone upper-lane allocation and flush.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_valid;
    logic [9:0]  alloc_dst_reg;
    logic [63:0] alloc_pc;
    logic [9:0]  alloc_idx;
    logic        rob_full;
    logic [3:0]  cmpl_valid;
    logic [19:0] cmpl_idx;
    logic [1:0]  retire_valid;
    logic [9:0]  retire_dst_reg;
    logic [63:0] retire_pc;
    logic [5:0]  rob_count;
`ifdef ROB_FLUSH_EN
    logic        flush;
`endif

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ROB_FLUSH_EN
        .flush          (flush),
`endif
        .alloc_valid    (alloc_valid),
        .alloc_dst_reg  (alloc_dst_reg),
        .alloc_pc       (alloc_pc),
        .alloc_idx      (alloc_idx),
        .rob_full       (rob_full),
        .cmpl_valid     (cmpl_valid),
        .cmpl_idx       (cmpl_idx),
        .retire_valid   (retire_valid),
        .retire_dst_reg (retire_dst_reg),
        .retire_pc      (retire_pc),
        .rob_count      (rob_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] alloc;
        logic [3:0] cv;
        logic [4:0] ci0, ci1, ci2, ci3;
        logic [1:0] exp_ret;
        int         exp_cnt;
        logic [4:0] exp_a0, exp_a1;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 2'b00;
        alloc_dst_reg = '0;
        alloc_pc      = '0;
        cmpl_valid    = 4'b0000;
        cmpl_idx      = '0;
`ifdef ROB_FLUSH_EN
        flush         = 1'b0;
`endif
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && rob_count != 0; k++) tick();
        check(name, 32'(rob_count), 0);
    endtask

    logic [4:0] p0, p1;
    logic [1:0] pm;
    int         et;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //               alloc  cv       ci0    ci1    ci2    ci3    ret    cnt a0     a1
        tbl = '{
            '{2'b11, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 0, 5'd0,  5'd1},
            '{2'b11, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 2, 5'd2,  5'd3},
            '{2'b00, 4'b0111, 5'd3,  5'd2,  5'd1,  5'd0,  2'b00, 4, 5'd4,  5'd4},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 4, 5'd4,  5'd4},
            '{2'b00, 4'b1000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 4, 5'd4,  5'd4},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b11, 4, 5'd4,  5'd4},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b11, 2, 5'd4,  5'd4},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 0, 5'd4,  5'd4},
            '{2'b11, 4'b0011, 5'd4,  5'd5,  5'd0,  5'd0,  2'b00, 0, 5'd4,  5'd5},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 2, 5'd6,  5'd6},
            '{2'b00, 4'b1011, 5'd5,  5'd5,  5'd0,  5'd7,  2'b00, 2, 5'd6,  5'd6},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 2, 5'd6,  5'd6},
            '{2'b00, 4'b0100, 5'd0,  5'd0,  5'd4,  5'd0,  2'b00, 2, 5'd6,  5'd6},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b11, 2, 5'd6,  5'd6},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 0, 5'd6,  5'd6},
            '{2'b11, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 0, 5'd6,  5'd7},
            '{2'b00, 4'b0001, 5'd6,  5'd0,  5'd0,  5'd0,  2'b00, 2, 5'd8,  5'd8},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b01, 2, 5'd8,  5'd8},
            '{2'b00, 4'b0001, 5'd7,  5'd0,  5'd0,  5'd0,  2'b00, 1, 5'd8,  5'd8},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b01, 1, 5'd8,  5'd8},
            '{2'b00, 4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 0, 5'd8,  5'd8}
        };

        // ---- T1: reset ----
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t1_count", 32'(rob_count), 0);
        check("t1_full", 32'(rob_full), 0);
        check("t1_retire", 32'(retire_valid), 0);
        check("t1_alloc_idx", 32'(alloc_idx), 0);

        // ---- T2: fill two per cycle, no completions ----
        for (int n = 0; n < 16; n++) begin
            alloc_valid   = 2'b11;
            alloc_pc      = {32'h100 + 32'(8*n + 4), 32'h100 + 32'(8*n)};
            alloc_dst_reg = {5'(2*n + 1), 5'(2*n)};
            #1;
            check("t2_idx0", 32'(alloc_idx[4:0]), 32'(2*n));
            check("t2_idx1", 32'(alloc_idx[9:5]), 32'(2*n + 1));
            check("t2_full_low", 32'(rob_full), 0);
            tick();
        end
        idle();
        cmpl_valid = 4'b1111;
        cmpl_idx   = {5'd3, 5'd2, 5'd1, 5'd0};
        #1;
        check("t2_count_full", 32'(rob_count), 32);
        check("t2_full", 32'(rob_full), 1);
        check("t2_no_retire", 32'(retire_valid), 0);
        tick();
        idle();
        #1;
        // Retire is visible immediately; freed slots reach rob_full a cycle later.
        check("t2_ret_a", 32'(retire_valid), 32'h3);
        check("t2_pc_a0", retire_pc[31:0], 32'h100);
        check("t2_pc_a1", retire_pc[63:32], 32'h104);
        check("t2_dst_a1", 32'(retire_dst_reg[9:5]), 1);
        check("t2_full_still", 32'(rob_full), 1);
        tick();
        check("t2_ret_b", 32'(retire_valid), 32'h3);
        check("t2_pc_b0", retire_pc[31:0], 32'h108);
        check("t2_pc_b1", retire_pc[63:32], 32'h10c);
        check("t2_count_30", 32'(rob_count), 30);
        check("t2_full_clear", 32'(rob_full), 0);
        tick();
        check("t2_count_28", 32'(rob_count), 28);

        // ---- reset in mid-operation ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_count", 32'(rob_count), 0);
        check("rst_mid_retire", 32'(retire_valid), 0);
        check("rst_mid_full", 32'(rob_full), 0);

        // ---- T3: table of out-of-order / same-cycle / duplicate completions ----
        for (int v = 0; v < 21; v++) begin
            alloc_valid   = tbl[v].alloc;
            alloc_pc      = {32'h1004 + 32'(8*v), 32'h1000 + 32'(8*v)};
            alloc_dst_reg = '0;
            cmpl_valid    = tbl[v].cv;
            cmpl_idx      = {tbl[v].ci3, tbl[v].ci2, tbl[v].ci1, tbl[v].ci0};
            #1;
            check($sformatf("t3_v%0d_retire", v), 32'(retire_valid), 32'(tbl[v].exp_ret));
            check($sformatf("t3_v%0d_count", v), 32'(rob_count), tbl[v].exp_cnt);
            check($sformatf("t3_v%0d_idx0", v), 32'(alloc_idx[4:0]), 32'(tbl[v].exp_a0));
            check($sformatf("t3_v%0d_idx1", v), 32'(alloc_idx[9:5]), 32'(tbl[v].exp_a1));
            check($sformatf("t3_v%0d_full", v), 32'(rob_full), 0);
            tick();
        end
        idle();

        // ---- advance head/tail from 8 to 31 with a streaming alloc/complete ----
        et = 8;
        pm = 2'b00;
        p0 = '0;
        p1 = '0;
        for (int k = 0; k < 12; k++) begin
            alloc_valid = (k < 11) ? 2'b11 : 2'b01;
            alloc_pc    = {32'h2000 + 32'(4*et + 4), 32'h2000 + 32'(4*et)};
            cmpl_valid  = {2'b00, pm};
            cmpl_idx    = {10'd0, p1, p0};
            #1;
            check("fill_idx0", 32'(alloc_idx[4:0]), 32'(et));
            p0 = 5'(et);
            p1 = 5'(et + 1);
            pm = alloc_valid;
            et = et + ((k < 11) ? 2 : 1);
            tick();
        end
        alloc_valid = 2'b00;
        cmpl_valid  = {2'b00, pm};
        cmpl_idx    = {10'd0, p1, p0};
        tick();
        idle();
        drain("fill_drain");

        // ---- T4: two-lane alloc and retire straddling the wrap ----
        #1;
        check("t4_tail31", 32'(alloc_idx[4:0]), 31);
        alloc_valid = 2'b11;
        alloc_pc    = {32'h304, 32'h300};
        #1;
        check("t4_idx0", 32'(alloc_idx[4:0]), 31);
        check("t4_idx1", 32'(alloc_idx[9:5]), 0);
        tick();
        idle();
        cmpl_valid = 4'b0011;
        cmpl_idx   = {10'd0, 5'd0, 5'd31};
        tick();
        idle();
        #1;
        check("t4_retire", 32'(retire_valid), 32'h3);
        check("t4_pc0", retire_pc[31:0], 32'h300);
        check("t4_pc1", retire_pc[63:32], 32'h304);
        tick();
        check("t4_count", 32'(rob_count), 0);
        check("t4_tail1", 32'(alloc_idx[4:0]), 1);

        // ---- move tail to 5 ----
        alloc_valid = 2'b11;
        tick();
        cmpl_valid = 4'b0011;
        cmpl_idx   = {10'd0, 5'd2, 5'd1};
        tick();
        alloc_valid = 2'b00;
        cmpl_idx    = {10'd0, 5'd4, 5'd3};
        tick();
        idle();
        drain("t5_prep_drain");

        // ---- T5: lone lane-1 allocation takes the tail slot ----
        alloc_valid   = 2'b10;
        alloc_pc      = {32'h200, 32'hdead};
        alloc_dst_reg = {5'd7, 5'd0};
        #1;
        check("t5_idx1", 32'(alloc_idx[9:5]), 5);
        tick();
        idle();
        cmpl_valid = 4'b0100;
        cmpl_idx   = {5'd0, 5'd5, 10'd0};
        tick();
        idle();
        #1;
        check("t5_retire", 32'(retire_valid), 32'h1);
        check("t5_pc", retire_pc[31:0], 32'h200);
        check("t5_dst", 32'(retire_dst_reg[4:0]), 7);
        tick();
        check("t5_count", 32'(rob_count), 0);

`ifdef ROB_FLUSH_EN
        // ---- T6: flush overrides alloc and retire ----
        for (int k = 0; k < 5; k++) begin
            alloc_valid = 2'b11;
            tick();
        end
        idle();
        cmpl_valid = 4'b0111;
        cmpl_idx   = {5'd0, 5'd8, 5'd7, 5'd6};
        tick();
        idle();
        #1;
        check("t6_count10", 32'(rob_count), 10);
        check("t6_pre_retire", 32'(retire_valid), 32'h3);
        flush       = 1'b1;
        alloc_valid = 2'b11;
        #1;
        check("t6_flush_retire", 32'(retire_valid), 0);
        tick();
        idle();
        #1;
        check("t6_count0", 32'(rob_count), 0);
        check("t6_retire0", 32'(retire_valid), 0);
        check("t6_idx_restart", 32'(alloc_idx[4:0]), 0);
        alloc_valid = 2'b11;
        #1;
        check("t6_idx1", 32'(alloc_idx[9:5]), 1);
        tick();
        idle();
        #1;
        check("t6_count2", 32'(rob_count), 2);
        check("t6_fresh_not_done", 32'(retire_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
